// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// mem_port_arbiter: shares one single-ported memory between fetch and load/store
// Revision: 1.0
// ============================================================================

module mem_port_arbiter #(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned MAX_D_STREAK   = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [DATA_W-1:0] if_rdata_o,
  output logic              if_ack_o,
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [DATA_W-1:0] d_wdata_i,
  output logic [DATA_W-1:0] d_rdata_o,
  output logic              d_ack_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              mem_ready_i,
  output logic              stall_o,
  output logic              err_o
);

  localparam int unsigned TIMER_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned STREAK_W = $clog2(MAX_D_STREAK + 1);

  localparam logic [TIMER_W-1:0]  TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_D_STREAK);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_BUSY_IF = 2'd1;
  localparam logic [1:0] ST_BUSY_D  = 2'd2;

  logic [1:0]          state_q,     state_d;
  logic [STREAK_W-1:0] streak_q,    streak_d;
  logic [TIMER_W-1:0]  timer_q,     timer_d;
  logic                mem_req_q,   mem_req_d;
  logic                mem_we_q,    mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q,  mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0]   if_rdata_q,  if_rdata_d;
  logic [DATA_W-1:0]   d_rdata_q,   d_rdata_d;
  logic                if_ack_q,    if_ack_d;
  logic                d_ack_q,     d_ack_d;
  logic                err_q,       err_d;

  logic if_elig;
  logic d_elig;
  logic grant_d;
  logic grant_if;
  logic owner_d;

  // A requester still holding req during its own ack cycle is not re-granted.
  assign if_elig  = if_req_i & ~if_ack_q;
  assign d_elig   = d_req_i & ~d_ack_q;
  assign grant_d  = d_elig & (~if_elig | (streak_q != STREAK_MAX));
  assign grant_if = if_elig & ~grant_d;
  assign owner_d  = (state_q == ST_BUSY_D);

  always_comb begin
    state_d     = state_q;
    streak_d    = streak_q;
    timer_d     = timer_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    if_ack_d    = 1'b0;
    d_ack_d     = 1'b0;
    err_d       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (grant_d) begin
          state_d     = ST_BUSY_D;
          mem_req_d   = 1'b1;
          mem_we_d    = d_we_i;
          mem_addr_d  = d_addr_i;
          mem_wdata_d = d_wdata_i;
          timer_d     = '0;
          if (!if_req_i) begin
            streak_d = '0;
          end else if (streak_q != STREAK_MAX) begin
            streak_d = streak_q + STREAK_W'(1);
          end
        end else if (grant_if) begin
          state_d    = ST_BUSY_IF;
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = if_addr_i;
          timer_d    = '0;
          streak_d   = '0;
        end
      end

      ST_BUSY_IF, ST_BUSY_D: begin
        if (mem_ready_i) begin
          // Stores capture read data too; the value is simply unused.
          state_d   = ST_IDLE;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          if (owner_d) begin
            d_ack_d   = 1'b1;
            d_rdata_d = mem_rdata_i;
          end else begin
            if_ack_d   = 1'b1;
            if_rdata_d = mem_rdata_i;
          end
        end else if (timer_q == TIMER_LAST) begin
          state_d   = ST_IDLE;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          err_d     = 1'b1;
          if (owner_d) begin
            d_ack_d   = 1'b1;
            d_rdata_d = '0;
          end else begin
            if_ack_d   = 1'b1;
            if_rdata_d = '0;
          end
        end else begin
          timer_d = timer_q + TIMER_W'(1);
        end
      end

      default: begin
        state_d   = ST_IDLE;
        mem_req_d = 1'b0;
        mem_we_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= ST_IDLE;
      streak_q    <= '0;
      timer_q     <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      if_ack_q    <= 1'b0;
      d_ack_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      streak_q    <= streak_d;
      timer_q     <= timer_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      if_ack_q    <= if_ack_d;
      d_ack_q     <= d_ack_d;
      err_q       <= err_d;
    end
  end

  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign if_rdata_o  = if_rdata_q;
  assign d_rdata_o   = d_rdata_q;
  assign if_ack_o    = if_ack_q;
  assign d_ack_o     = d_ack_q;
  assign err_o       = err_q;
  assign stall_o     = (if_req_i & ~if_ack_q) | (d_req_i & ~d_ack_q);

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// tb_mem_port_arbiter: directed and random checks against a transaction model
// Revision: 1.0
// ============================================================================

module tb_mem_port_arbiter;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int TO   = 16;
  localparam int MAXS = 4;

  logic          clk_i;
  logic          rst_i;
  logic          if_req_i;
  logic [AW-1:0] if_addr_i;
  logic [DW-1:0] if_rdata_o;
  logic          if_ack_o;
  logic          d_req_i;
  logic          d_we_i;
  logic [AW-1:0] d_addr_i;
  logic [DW-1:0] d_wdata_i;
  logic [DW-1:0] d_rdata_o;
  logic          d_ack_o;
  logic          mem_req_o;
  logic          mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o;
  logic [DW-1:0] mem_rdata_i;
  logic          mem_ready_i;
  logic          stall_o;
  logic          err_o;

  mem_port_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO), .MAX_D_STREAK(MAXS)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_rdata_o(if_rdata_o), .if_ack_o(if_ack_o),
    .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i),
    .d_rdata_o(d_rdata_o), .d_ack_o(d_ack_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .mem_ready_i(mem_ready_i),
    .stall_o(stall_o), .err_o(err_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;
  int p_ready;

  // Transaction-level model of the arbiter
  bit          m_busy;
  bit          m_owner_d;
  int          m_wait;
  logic [AW-1:0] m_addr;
  bit          m_we;
  logic [DW-1:0] m_wdata;
  int          m_streak;
  bit          e_if_ack, e_d_ack, e_err;
  logic [DW-1:0] e_if_rdata, e_d_rdata;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_owner_d = 0; m_wait = 0; m_addr = '0; m_we = 0; m_wdata = '0;
    m_streak = 0; e_if_ack = 0; e_d_ack = 0; e_err = 0; e_if_rdata = '0; e_d_rdata = '0;
  endtask

  task automatic model_next();
    bit n_ifa, n_da, n_err, ef, ed;
    n_ifa = 0; n_da = 0; n_err = 0;
    if (m_busy) begin
      if (mem_ready_i) begin
        if (m_owner_d) begin n_da = 1; e_d_rdata = mem_rdata_i; end
        else begin n_ifa = 1; e_if_rdata = mem_rdata_i; end
        m_busy = 0;
      end else begin
        m_wait++;
        if (m_wait == TO) begin
          n_err = 1;
          if (m_owner_d) begin n_da = 1; e_d_rdata = '0; end
          else begin n_ifa = 1; e_if_rdata = '0; end
          m_busy = 0;
        end
      end
    end else begin
      ef = if_req_i && !e_if_ack;
      ed = d_req_i && !e_d_ack;
      if (ed && (!ef || m_streak < MAXS)) begin
        m_busy = 1; m_owner_d = 1; m_wait = 0;
        m_addr = d_addr_i; m_we = d_we_i; m_wdata = d_wdata_i;
        m_streak = if_req_i ? ((m_streak + 1 > MAXS) ? MAXS : m_streak + 1) : 0;
      end else if (ef) begin
        m_busy = 1; m_owner_d = 0; m_wait = 0;
        m_addr = if_addr_i; m_we = 0;
        m_streak = 0;
      end
    end
    e_if_ack = n_ifa; e_d_ack = n_da; e_err = n_err;
  endtask

  task automatic check_outputs();
    chk("mem_req", mem_req_o, m_busy);
    if (m_busy) begin
      chk("mem_addr", mem_addr_o, m_addr);
      chk("mem_we", mem_we_o, m_we);
      if (m_we) chk("mem_wdata", mem_wdata_o, m_wdata);
    end
    chk("if_ack", if_ack_o, e_if_ack);
    chk("d_ack", d_ack_o, e_d_ack);
    chk("err", err_o, e_err);
    chk("if_rdata", if_rdata_o, e_if_rdata);
    chk("d_rdata", d_rdata_o, e_d_rdata);
  endtask

  // One clock cycle: check stall with current inputs, predict, advance, check.
  task automatic step();
    #1;
    chk("stall", stall_o, (if_req_i && !e_if_ack) || (d_req_i && !e_d_ack));
    if (!rst_i) model_reset();
    else model_next();
    @(posedge clk_i);
    #1;
    check_outputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    rst_i = 1'b1;
    if_req_i = 0; if_addr_i = '0; d_req_i = 0; d_we_i = 0; d_addr_i = '0; d_wdata_i = '0;
    mem_rdata_i = '0; mem_ready_i = 0;
    model_reset();
    #1 rst_i = 1'b0;
    #1 check_outputs();
    @(posedge clk_i); #1;
    check_outputs();
    chk("reset_stall", stall_o, 1'b0);
    rst_i = 1'b1;
    step();

    // Fetch only: ack two cycles after request
    if_req_i = 1; if_addr_i = 32'h0000_0040;
    step();
    chk("t1_mem_req", mem_req_o, 1'b1);
    chk("t1_addr", mem_addr_o, 32'h0000_0040);
    mem_ready_i = 1; mem_rdata_i = 32'h2002_0005;
    step();
    chk("t1_ack", if_ack_o, 1'b1);
    chk("t1_rdata", if_rdata_o, 32'h2002_0005);
    mem_ready_i = 0;
    #1 chk("t1_stall_low", stall_o, 1'b0);
    if_req_i = 0;
    step();
    chk("t1_ack_pulse", if_ack_o, 1'b0);

    // Simultaneous requests: data first, then fetch, no data regrant
    if_req_i = 1; if_addr_i = 32'h200;
    d_req_i = 1; d_we_i = 1; d_addr_i = 32'h100; d_wdata_i = 32'h1234_5678;
    step();
    chk("t2_we", mem_we_o, 1'b1);
    chk("t2_addr", mem_addr_o, 32'h100);
    chk("t2_wdata", mem_wdata_o, 32'h1234_5678);
    mem_ready_i = 1; mem_rdata_i = 32'hDEAD_BEEF;
    step();
    chk("t2_d_ack", d_ack_o, 1'b1);
    mem_ready_i = 0;
    step();
    chk("t2_fetch_addr", mem_addr_o, 32'h200);
    chk("t2_fetch_we", mem_we_o, 1'b0);
    d_req_i = 0; mem_ready_i = 1; mem_rdata_i = 32'h0BAD_F00D;
    step();
    chk("t2_if_ack", if_ack_o, 1'b1);
    chk("t2_if_rdata", if_rdata_o, 32'h0BAD_F00D);
    if_req_i = 0; mem_ready_i = 0;
    step();

    // Anti-starvation: four data grants with fetch waiting, then fetch
    d_we_i = 0; if_addr_i = 32'h300;
    for (int k = 0; k < MAXS; k++) begin
      d_req_i = 1; d_addr_i = 32'h1000 + 32'(k * 4); if_req_i = 1; mem_ready_i = 0;
      step();
      chk("t3_data_grant", mem_addr_o, 32'h1000 + 32'(k * 4));
      mem_ready_i = 1; mem_rdata_i = $urandom;
      step();
      chk("t3_d_ack", d_ack_o, 1'b1);
      if_req_i = 0; mem_ready_i = 0;
      step();
      chk("t3_idle", mem_req_o, 1'b0);
    end
    if_req_i = 1; d_req_i = 1; d_addr_i = 32'h2000;
    step();
    chk("t3_fetch_wins", mem_addr_o, 32'h300);
    chk("t3_fetch_we", mem_we_o, 1'b0);
    mem_ready_i = 1; mem_rdata_i = 32'hA5A5_0001;
    step();
    chk("t3_if_ack", if_ack_o, 1'b1);
    if_req_i = 0; d_req_i = 0; mem_ready_i = 0;
    step();
    if_req_i = 1; d_req_i = 1; d_addr_i = 32'h2004;
    step();
    chk("t3_streak_cleared", mem_addr_o, 32'h2004);
    mem_ready_i = 1; mem_rdata_i = 32'h5A5A_0002;
    step();
    if_req_i = 0; d_req_i = 0; mem_ready_i = 0;
    step();
    step();

    // Timeout: no ready for TIMEOUT_CYCLES busy cycles
    d_req_i = 1; d_we_i = 0; d_addr_i = 32'h500;
    step();
    d_req_i = 0;
    for (int i = 1; i < TO; i++) begin
      step();
      chk("t4_hold", mem_req_o, 1'b1);
    end
    step();
    chk("t4_req_drop", mem_req_o, 1'b0);
    chk("t4_ack", d_ack_o, 1'b1);
    chk("t4_err", err_o, 1'b1);
    chk("t4_rdata_zero", d_rdata_o, 32'h0);
    step();
    d_req_i = 1; d_addr_i = 32'h504;
    step();
    d_req_i = 0;
    for (int i = 1; i < TO; i++) step();
    mem_ready_i = 1; mem_rdata_i = 32'hCAFE_F00D;
    step();
    chk("t4b_ack", d_ack_o, 1'b1);
    chk("t4b_no_err", err_o, 1'b0);
    chk("t4b_rdata", d_rdata_o, 32'hCAFE_F00D);
    mem_ready_i = 0;
    step();

    // Asynchronous reset in the middle of a data access
    if_req_i = 1; if_addr_i = 32'h600;
    d_req_i = 1; d_we_i = 1; d_addr_i = 32'h700; d_wdata_i = 32'h55AA_55AA;
    step();
    chk("t5_busy_d", mem_we_o, 1'b1);
    step();
    step();
    #2 rst_i = 1'b0;
    #1;
    model_reset();
    chk("t5_async_req", mem_req_o, 1'b0);
    check_outputs();
    d_req_i = 0;
    step();
    rst_i = 1'b1;
    step();
    chk("t5_fetch_grant", mem_addr_o, 32'h600);
    chk("t5_fetch_we", mem_we_o, 1'b0);
    mem_ready_i = 1; mem_rdata_i = 32'h1111_2222;
    step();
    chk("t5_if_ack", if_ack_o, 1'b1);
    chk("t5_if_rdata", if_rdata_o, 32'h1111_2222);
    if_req_i = 0; mem_ready_i = 0;
    step();

    // Random traffic, alternating responsive and sluggish memory
    for (int c = 0; c < 3000; c++) begin
      p_ready = (((c / 200) % 2) == 0) ? 60 : 4;
      if_req_i    = ($urandom_range(0, 99) < 60);
      if_addr_i   = $urandom;
      d_req_i     = ($urandom_range(0, 99) < 60);
      d_we_i      = 1'($urandom_range(0, 1));
      d_addr_i    = $urandom;
      d_wdata_i   = $urandom;
      mem_ready_i = ($urandom_range(0, 99) < p_ready);
      mem_rdata_i = $urandom;
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
